// File: rtl/rpu_pkg.sv
// Types and constants shared by rpu_top and the sensor-stream transmitter.
package rpu_pkg;

    localparam int SENSOR_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        READY,
        SEND,
        GAP
    } tx_state_t;

endpackage

// File: rtl/sync_fifo_ptr.sv
// DEPTH x DATA_W synchronous FIFO with wrap-around pointers and same-cycle push/pop.
import rpu_pkg::*;

module sync_fifo_ptr #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              do_push;
    logic              do_pop;

    // A push into a full FIFO is still taken when a pop frees the head slot in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign rdata = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sensor_stream_tx.sv
// Buffers sensor samples and paces them into rpu_top as one-cycle data_valid pulses
// separated by a guaranteed idle gap, once armed by start.
import rpu_pkg::*;

module sensor_stream_tx #(
    parameter int DATA_W      = SENSOR_W,
    parameter int DEPTH       = 4,
    parameter int GAP_CYCLES  = 4,
    parameter int START_DELAY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_wr,
    output logic [DATA_W-1:0] sensor_data,
    output logic              data_valid,
    output logic              fifo_full,
    output logic              fifo_empty,
    output logic              overflow,
    output logic              busy
);

    localparam int CNT_MAX = (GAP_CYCLES > START_DELAY) ? GAP_CYCLES : START_DELAY;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    tx_state_t         state;
    tx_state_t         state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              stop_pend;
    logic              stop_pend_nxt;
    logic              pop;
    logic              start_ok;
    logic [DATA_W-1:0] fifo_head;

    // Interface: sample_wr is a strobe with no ready (a push into a full FIFO is dropped and
    // flagged in overflow); data_valid qualifies sensor_data for one cycle with no backpressure.
    sync_fifo_ptr #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (sample_wr),
        .pop   (pop),
        .wdata (sample_in),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign data_valid = (state == SEND);
    assign busy       = (state != IDLE);

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        stop_pend_nxt = stop_pend;
        pop           = 1'b0;
        start_ok      = 1'b0;
        case (state)
            IDLE: begin
                stop_pend_nxt = 1'b0;
                if (start && !stop) begin
                    start_ok = 1'b1;
                    if (START_DELAY == 0) begin
                        state_nxt = READY;
                    end else begin
                        state_nxt = ARM;
                        cnt_nxt   = CNT_W'(START_DELAY);
                    end
                end
            end
            ARM: begin
                if (stop) begin
                    state_nxt = IDLE;
                end else if (cnt == '0) begin
                    state_nxt = READY;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            READY: begin
                if (stop) begin
                    state_nxt = IDLE;
                end else if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                stop_pend_nxt = stop_pend || stop;
                state_nxt     = GAP;
                cnt_nxt       = CNT_W'(GAP_CYCLES);
            end
            GAP: begin
                stop_pend_nxt = stop_pend || stop;
                // cnt==1 marks the last gap cycle; the next pulse may issue on this edge.
                if (cnt == CNT_W'(1)) begin
                    if (stop_pend || stop) begin
                        state_nxt     = IDLE;
                        stop_pend_nxt = 1'b0;
                    end else if (!fifo_empty) begin
                        pop       = 1'b1;
                        state_nxt = SEND;
                    end else begin
                        state_nxt = READY;
                    end
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            stop_pend   <= 1'b0;
            overflow    <= 1'b0;
            sensor_data <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            stop_pend <= stop_pend_nxt;
            if (sample_wr && fifo_full && !pop) begin
                overflow <= 1'b1;
            end else if (start_ok) begin
                overflow <= 1'b0;
            end
            if (pop) begin
                sensor_data <= fifo_head;
            end
        end
    end

endmodule

// File: tb/tb_sensor_stream_tx.sv
// Directed bench for sensor_stream_tx: a vector table for reset/basic streaming plus
// hand-written sequences for overflow, stop-in-gap, full push/pop and reset-in-send.
module tb_sensor_stream_tx;

    logic       clk;
    logic       rst;
    logic       start;
    logic       stop;
    logic [7:0] sample_in;
    logic       sample_wr;
    logic [7:0] sensor_data;
    logic       data_valid;
    logic       fifo_full;
    logic       fifo_empty;
    logic       overflow;
    logic       busy;

    int n_checks;
    int n_errors;
    int cyc;
    int last_pulse;
    int first_at;
    logic [7:0] exp_q[$];

    typedef struct {
        logic       rst;
        logic       start;
        logic       stop;
        logic       wr;
        logic [7:0] din;
        logic       ev;
        logic [7:0] ed;
        logic       ef;
        logic       ee;
        logic       eo;
        logic       eb;
    } vec_t;

    vec_t vecs[$];

    sensor_stream_tx #(
        .DATA_W      (8),
        .DEPTH       (4),
        .GAP_CYCLES  (4),
        .START_DELAY (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .sample_in   (sample_in),
        .sample_wr   (sample_wr),
        .sensor_data (sensor_data),
        .data_valid  (data_valid),
        .fifo_full   (fifo_full),
        .fifo_empty  (fifo_empty),
        .overflow    (overflow),
        .busy        (busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic s, input logic p, input logic w,
                                input logic [7:0] d, input logic ev, input logic [7:0] ed,
                                input logic ef, input logic ee, input logic eo, input logic eb);
        vec_t v;
        v.rst = r; v.start = s; v.stop = p; v.wr = w; v.din = d;
        v.ev = ev; v.ed = ed; v.ef = ef; v.ee = ee; v.eo = eo; v.eb = eb;
        return v;
    endfunction

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        sample_wr = 1'b1;
        sample_in = d;
        step();
        sample_wr = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic go_idle();
        stop = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (!busy) break;
            step();
        end
        stop = 1'b0;
        chk("go_idle", busy, 0);
    endtask

    // scoreboard: pops exp_q on each pulse, checks data and pulse spacing
    task automatic run_stream(input int budget, output int first);
        int n;
        n = 0;
        first = -1;
        while (exp_q.size() > 0 && n < budget) begin
            step();
            n++;
            if (data_valid) begin
                chk("stream_data", sensor_data, exp_q.pop_front());
                if (last_pulse >= 0) chk("stream_spacing", cyc - last_pulse, 5);
                if (first < 0) first = n;
                last_pulse = cyc;
            end
        end
        chk("stream_timeout_left", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        int pulses;
        n_checks = 0; n_errors = 0; cyc = 0; last_pulse = -1;
        rst = 1'b0; start = 1'b0; stop = 1'b0; sample_wr = 1'b0; sample_in = 8'd0;

        // reset, idle without start, then push 55/100 and start at edge k
        vecs.push_back(mk(0,0,0,0,  0, 0,  0, 0,1,0,0));
        vecs.push_back(mk(0,0,0,0,  0, 0,  0, 0,1,0,0));
        for (int i = 0; i < 10; i++) vecs.push_back(mk(1,0,0,0,0, 0,0, 0,1,0,0));
        vecs.push_back(mk(1,0,0,1, 55, 0,  0, 0,0,0,0));
        vecs.push_back(mk(1,0,0,1,100, 0,  0, 0,0,0,0));
        vecs.push_back(mk(1,1,0,0,  0, 0,  0, 0,0,0,1));          // edge k: ARM
        for (int i = 0; i < 3; i++) vecs.push_back(mk(1,0,0,0,0, 0,0, 0,0,0,1));
        vecs.push_back(mk(1,0,0,0,  0, 1, 55, 0,0,0,1));          // k+4
        for (int i = 0; i < 4; i++) vecs.push_back(mk(1,0,0,0,0, 0,55, 0,0,0,1));
        vecs.push_back(mk(1,0,0,0,  0, 1,100, 0,1,0,1));          // k+9
        for (int i = 0; i < 5; i++) vecs.push_back(mk(1,0,0,0,0, 0,100, 0,1,0,1));
        vecs.push_back(mk(1,0,1,0,  0, 0,100, 0,1,0,0));          // stop in READY
        vecs.push_back(mk(1,1,1,0,  0, 0,100, 0,1,0,0));          // start+stop: stay IDLE
        vecs.push_back(mk(1,0,0,0,  0, 0,100, 0,1,0,0));

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst; start = vecs[i].start; stop = vecs[i].stop;
            sample_wr = vecs[i].wr; sample_in = vecs[i].din;
            step();
            chk($sformatf("v%0d_valid", i), data_valid, vecs[i].ev);
            chk($sformatf("v%0d_data", i),  sensor_data, vecs[i].ed);
            chk($sformatf("v%0d_full", i),  fifo_full, vecs[i].ef);
            chk($sformatf("v%0d_empty", i), fifo_empty, vecs[i].ee);
            chk($sformatf("v%0d_ovf", i),   overflow, vecs[i].eo);
            chk($sformatf("v%0d_busy", i),  busy, vecs[i].eb);
        end
        start = 1'b0; stop = 1'b0; sample_wr = 1'b0;

        // overflow: fifth push dropped, start clears the flag, stream 1..4
        for (int i = 1; i <= 4; i++) begin
            push(8'(i));
            chk($sformatf("t3_full_%0d", i), fifo_full, (i == 4));
        end
        push(8'd5);
        chk("t3_ovf_set", overflow, 1);
        chk("t3_full_kept", fifo_full, 1);
        step();
        chk("t3_ovf_sticky", overflow, 1);
        pulse_start();
        chk("t3_ovf_cleared", overflow, 0);
        exp_q = '{8'd1, 8'd2, 8'd3, 8'd4};
        last_pulse = -1;
        run_stream(60, first_at);
        chk("t3_latency", first_at, 4);
        chk("t3_empty_after", fifo_empty, 1);
        go_idle();

        // stop during first gap: only one pulse, two entries retained
        push(8'd10); push(8'd20); push(8'd30);
        pulse_start();
        exp_q = '{8'd10};
        last_pulse = -1;
        run_stream(20, first_at);
        step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("t4_busy_gap2", busy, 1);
        step();
        step();
        chk("t4_busy_gap4", busy, 1);
        chk("t4_no_pulse", data_valid, 0);
        step();
        chk("t4_idle_after_gap", busy, 0);
        chk("t4_data_held", sensor_data, 10);
        chk("t4_not_empty", fifo_empty, 0);
        push(8'd40);
        chk("t4_three_not_full", fifo_full, 0);
        push(8'd50);
        chk("t4_four_full", fifo_full, 1);
        chk("t4_ovf", overflow, 0);

        // full FIFO: push on the same edge as the gap-end pop
        pulse_start();
        exp_q = '{8'd20};
        last_pulse = -1;
        run_stream(20, first_at);
        step();
        sample_wr = 1'b1; sample_in = 8'd60;
        step();
        sample_wr = 1'b0;
        chk("t5_full_in_gap", fifo_full, 1);
        step();
        step();
        sample_wr = 1'b1; sample_in = 8'd70;
        step();
        sample_wr = 1'b0;
        chk("t5_pulse", data_valid, 1);
        chk("t5_data", sensor_data, 30);
        chk("t5_full_kept", fifo_full, 1);
        chk("t5_ovf_clear", overflow, 0);
        last_pulse = cyc;
        exp_q = '{8'd40, 8'd50, 8'd60, 8'd70};
        run_stream(40, first_at);
        chk("t5_empty_after", fifo_empty, 1);
        chk("t5_ovf_end", overflow, 0);

        // reset during SEND
        push(8'd80);
        exp_q = '{8'd80};
        last_pulse = -1;
        run_stream(20, first_at);
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("t6_valid", data_valid, 0);
        chk("t6_empty", fifo_empty, 1);
        chk("t6_busy", busy, 0);
        chk("t6_data", sensor_data, 0);
        pulse_start();
        chk("t6_armed", busy, 1);
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (data_valid) pulses++;
        end
        chk("t6_no_pulse", pulses, 0);
        go_idle();

        // final report
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sensor_stream_tx.md
Name: sensor_stream_tx

Overview:
Transmitter side of the RPU sensor-input interface. It buffers raw sensor samples from the acquisition side and drives sensor_data/data_valid into rpu_top. Each sample is sent as a one-cycle data_valid pulse, with a guaranteed minimum idle gap between pulses, and only after an arming start. The block sits between the sensor capture logic and rpu_top in the top-level integration.

Parameters:
DATA_W, 8, sample and sensor_data width
DEPTH, 4, sample FIFO entries; must be a power of 2 and at least 2
GAP_CYCLES, 4, minimum data_valid-low cycles after each pulse; must be at least 1
START_DELAY, 2, cycles spent in ARM after start before the first pulse may issue; may be 0

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  reset, synchronous, active-low (0 = reset)
start  in  1  arms the transmitter; sampled in IDLE only
stop  in  1  request to return to IDLE
sample_in  in  DATA_W  sample to enqueue
sample_wr  in  1  enqueue strobe for sample_in
sensor_data  out  DATA_W  registered sample to rpu_top; held stable between pulses
data_valid  out  1  one-cycle qualifier for sensor_data
fifo_full  out  1  FIFO holds DEPTH entries
fifo_empty  out  1  FIFO holds 0 entries
overflow  out  1  sticky flag: a write was dropped
busy  out  1  high when state is not IDLE

Behaviour:
- Reset (rst=0 at an edge): state IDLE; FIFO pointers and count cleared. Outputs: sensor_data=0, data_valid=0, fifo_empty=1, fifo_full=0, overflow=0, busy=0. Reset mid-transfer drops any pulse in progress; data_valid is 0 in the next cycle.
- FIFO: read and write pointers wrap modulo DEPTH. Pushes are accepted in every state.
  - Push with sample_wr=1 and not full: entry enqueued.
  - Push when full with no pop in the same cycle: sample dropped, overflow set to 1.
  - Push and pop in the same cycle while full: both succeed, count unchanged, overflow not set.
  - Push and pop in the same cycle while count=1: both succeed; the popped value is the old head.
- overflow is cleared only by reset or by an accepted start.
- States:
  - IDLE: data_valid=0. start=1 and stop=0 → ARM, with the counter loaded to START_DELAY. If START_DELAY=0, go to READY instead. start is ignored in all other states.
  - ARM: counter decrements each cycle; at 0 → READY. stop=1 → IDLE.
  - READY: if the FIFO is not empty, pop the head into the sensor_data register and go to SEND. stop=1 has priority over the pop → IDLE.
  - SEND: data_valid=1 for exactly this cycle; sensor_data carries the popped sample. Next state is GAP with the counter loaded to GAP_CYCLES.
  - GAP: data_valid=0; counter decrements. At the last gap cycle, if the FIFO is not empty and no stop is pending, pop and go directly to SEND; otherwise go to READY, or to IDLE if a stop is pending.
- stop during SEND or GAP is latched as pending. The current pulse and its full gap complete, then the block goes to IDLE. FIFO contents are retained.
- start and stop asserted together in IDLE: stop wins, and the block stays in IDLE.
- Latency: start sampled at edge k gives the first data_valid in cycle k+2+START_DELAY when the FIFO is already non-empty.
- Back-to-back data_valid rising edges are exactly GAP_CYCLES+1 cycles apart while the FIFO stays non-empty, and never closer.
- sensor_data changes only on a pop.

Decomposition:
- rpu_pkg holds:
  - tx_state_t enum (IDLE, ARM, READY, SEND, GAP);
  - the shared SENSOR_W=8 constant used by rpu_top and this block.
- One sub-module, sync_fifo_ptr: a DEPTH x DATA_W storage array with wrap-around pointers, count, full/empty, and same-cycle push/pop. Its reset is synchronous and active-low, and it is parameterized by DATA_W and DEPTH.
- The FSM, counters, sticky overflow and output registers stay in sensor_stream_tx.

Test Plan:
1. Hold rst=0 for 2 cycles, then release → all outputs 0, fifo_empty=1, busy=0; no data_valid for 10 cycles with no start.
2. Push 55 then 100 in IDLE, pulse start at edge k → data_valid=1 with sensor_data=55 in cycle k+4, and with 100 in cycle k+9. sensor_data stays 100 afterwards, and busy stays 1 in READY.
3. Push 5 samples (1,2,3,4,5) in IDLE → fifo_full=1 after the 4th push; 5 dropped, overflow=1. After start, the emitted sequence is 1,2,3,4 with 5-cycle spacing, then fifo_empty=1.
4. Preload 3 samples, start, assert stop during the first GAP → only the first sample is emitted. IDLE is entered after the gap completes, with 2 entries still in the FIFO.
5. Full FIFO in GAP with a push at the same edge as a pop → count stays 4, overflow stays 0, and the new sample is emitted last in order.
6. Assert rst=0 during a SEND cycle → data_valid=0 the next cycle, FIFO empty, state IDLE. The next start with no pushes produces no pulse.
